frame_dma: RTL and testbench

//  Parametrised pixel-stream-to-memory DMA, successor to the single-byte capture DMA.

---
 rtl/frame_dma.sv | 189 ++++++++++++++++++
 tb/tb_frame_dma.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_dma.sv
// ---------------------------------------------------------------------------
// frame_dma
//
// Pixel-stream-to-memory DMA. Each word accepted from a valid/ready pixel
// stream becomes one registered memory write at base + offset. The write side
// supports backpressure. The offset can optionally wrap inside a ring of
// ring_size words. A transfer can be cancelled with abort. Busy and
// error/status pulses are reported alongside.
//
// Parameters
//   DATA_W  pixel / memory word width
//   ADDR_W  word-address width (address arithmetic wraps modulo 2^ADDR_W)
//   LEN_W   transfer-length and word-counter width
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            1-cycle launch; samples base/len/wrap_en/ring_size
//   abort            cancels the active transfer (no effect when idle)
//   base, len        first write address, number of words to move
//   wrap_en          ring mode: offset wraps back to 0 at ring_size
//   ring_size        ring length in words (0 means no wrap)
//   pix_valid/ready  stream handshake, pix_data is the stream word
//   wr_valid/ready   memory write handshake, wr_addr / wr_data payload
//   words_written    words accepted in the current / most recent transfer
//   busy             a transfer is in progress
//   done             1-cycle pulse: transfer completed normally
//   aborted          1-cycle pulse: transfer cancelled
//   start_err        1-cycle pulse: start seen while busy (start ignored)
// ---------------------------------------------------------------------------
module frame_dma #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic              wrap_en,
    input  logic [ADDR_W-1:0] ring_size,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [LEN_W-1:0]  words_written,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              start_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;

    // Transfer parameters captured at start, so the inputs may change freely
    // while a transfer is in flight.
    logic [ADDR_W-1:0] base_l;
    logic [ADDR_W-1:0] ring_size_l;
    logic [LEN_W-1:0]  len_l;
    logic              wrap_en_l;

    // Offset of the next word to be written, relative to base_l.
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] offset_inc;
    logic [ADDR_W-1:0] offset_next;

    logic [LEN_W-1:0]  words_next;
    logic              accept;
    logic              wr_fire;
    logic              last_word;

    // There is a single output register. A new word can be taken whenever
    // that register is empty or is being drained in this same cycle.
    assign busy      = (state != IDLE);
    assign pix_ready = (state == RUN) && (!wr_valid || wr_ready);
    assign accept    = pix_valid && pix_ready;
    assign wr_fire   = wr_valid && wr_ready;

    assign words_next = words_written + 1'b1;
    assign last_word  = (words_next == len_l);
    assign offset_inc = offset + 1'b1;

    // Ring wrap. A ring size of zero is treated as "no ring", so the offset
    // simply keeps counting (and wraps naturally at 2^ADDR_W).
    always_comb begin
        offset_next = offset_inc;
        if (wrap_en_l && (ring_size_l != '0) && (offset_inc == ring_size_l)) begin
            offset_next = '0;
        end
    end

    // Main control: state machine, write register, counters and status
    // pulses. Abort from any active state outranks every other event. A start
    // that arrives while busy only raises start_err and never disturbs the
    // running transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            base_l        <= '0;
            ring_size_l   <= '0;
            len_l         <= '0;
            wrap_en_l     <= 1'b0;
            offset        <= '0;
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            words_written <= '0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            start_err     <= 1'b0;
        end else begin
            done      <= 1'b0;
            aborted   <= 1'b0;
            start_err <= 1'b0;

            if (abort && (state != IDLE)) begin
                state    <= IDLE;
                wr_valid <= 1'b0;
                aborted  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (len != '0) begin
                                base_l        <= base;
                                len_l         <= len;
                                wrap_en_l     <= wrap_en;
                                ring_size_l   <= ring_size;
                                offset        <= '0;
                                words_written <= '0;
                                state         <= RUN;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end

                    RUN: begin
                        if (start) begin
                            start_err <= 1'b1;
                        end
                        // Drain first; a same-cycle accept below refills the
                        // register so wr_valid stays high back-to-back.
                        if (wr_fire) begin
                            wr_valid <= 1'b0;
                        end
                        if (accept) begin
                            wr_valid      <= 1'b1;
                            wr_addr       <= base_l + offset;
                            wr_data       <= pix_data;
                            words_written <= words_next;
                            offset        <= offset_next;
                            if (last_word) begin
                                state <= FLUSH;
                            end
                        end
                    end

                    FLUSH: begin
                        if (start) begin
                            start_err <= 1'b1;
                        end
                        if (wr_fire) begin
                            wr_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        wr_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_dma.sv
// ---------------------------------------------------------------------------
// tb_frame_dma
//
// Self-checking bench for frame_dma. Directed transfers are mixed with
// randomized ones. A transaction-level model tracks the number of words
// accepted and written in each transfer. Expected addresses come straight
// from base + (index mod ring) arithmetic.
// ---------------------------------------------------------------------------
module tb_frame_dma;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              wrap_en = 1'b0;
    logic [ADDR_W-1:0] ring_size = '0;
    logic              pix_valid = 1'b0;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data = '0;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [LEN_W-1:0]  words_written;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              start_err;

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the transfer in flight.
    bit          active = 1'b0;
    int          accIdx = 0;
    int          wrIdx  = 0;
    int          lenM   = 0;
    int          wwM    = 0;
    logic [15:0] baseM  = '0;
    logic [15:0] rsM    = '0;
    bit          wrapM  = 1'b0;
    logic [7:0]  dataMem [0:255];

    frame_dma #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .base         (base),
        .len          (len),
        .wrap_en      (wrap_en),
        .ring_size    (ring_size),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .words_written(words_written),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .start_err    (start_err)
    );

    always #5 clk = ~clk;

    // Address of word i of the current transfer.
    function automatic logic [15:0] expAddr(input int i);
        int off;
        off = (wrapM && rsM != 16'd0) ? (i % int'(rsM)) : i;
        return baseM + 16'(off);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive the inputs, check the pre-edge outputs against
    // the model, advance the model, then check the registered results.
    task automatic applyStimulus(input bit st, input logic [15:0] b, input logic [15:0] l,
                                 input bit w, input logic [15:0] rs, input bit ab,
                                 input bit pv, input bit rdy);
        bit expReady;
        bit acc;
        bit hs;
        bit accTaken;
        bit expDone;
        bit expAborted;
        bit expStartErr;

        start     = st;
        abort     = ab;
        base      = st ? b : 16'($urandom);
        len       = st ? l : 16'($urandom);
        wrap_en   = st ? w : 1'($urandom);
        ring_size = st ? rs : 16'($urandom);
        pix_valid = pv;
        wr_ready  = rdy;
        pix_data  = (active && accIdx < lenM) ? dataMem[accIdx] : 8'($urandom);
        #1;

        expReady = active && (accIdx < lenM) && ((accIdx == wrIdx) || rdy);
        checkOutput("busy", 32'(busy), 32'(active));
        checkOutput("wr_valid", 32'(wr_valid), 32'(accIdx > wrIdx));
        checkOutput("pix_ready", 32'(pix_ready), 32'(expReady));

        acc = pv && expReady;
        hs  = (accIdx > wrIdx) && rdy;
        if (hs) begin
            checkOutput("wr_addr", 32'(wr_addr), 32'(expAddr(wrIdx)));
            checkOutput("wr_data", 32'(wr_data), 32'(dataMem[wrIdx]));
        end

        expDone     = 1'b0;
        expAborted  = 1'b0;
        expStartErr = 1'b0;
        accTaken    = 1'b0;
        if (active) begin
            if (ab) begin
                active     = 1'b0;
                expAborted = 1'b1;
                accIdx     = 0;
                wrIdx      = 0;
            end else begin
                if (st) expStartErr = 1'b1;
                if (acc) begin
                    accIdx++;
                    wwM++;
                    accTaken = 1'b1;
                end
                if (hs) begin
                    wrIdx++;
                    if (wrIdx == lenM) begin
                        active  = 1'b0;
                        expDone = 1'b1;
                    end
                end
            end
        end else if (st) begin
            if (l != 16'd0) begin
                active = 1'b1;
                baseM  = b;
                lenM   = int'(l);
                wrapM  = w;
                rsM    = rs;
                accIdx = 0;
                wrIdx  = 0;
                wwM    = 0;
                for (int i = 0; i < 256; i++) dataMem[i] = 8'($urandom);
            end else begin
                expDone = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        checkOutput("done", 32'(done), 32'(expDone));
        checkOutput("aborted", 32'(aborted), 32'(expAborted));
        checkOutput("start_err", 32'(start_err), 32'(expStartErr));
        checkOutput("words_written", 32'(words_written), 32'(wwM));
        if (expAborted) checkOutput("wr_valid_after_abort", 32'(wr_valid), 32'd0);
        if (accTaken) begin
            checkOutput("latency_valid", 32'(wr_valid), 32'd1);
            checkOutput("latency_addr", 32'(wr_addr), 32'(expAddr(accIdx - 1)));
            checkOutput("latency_data", 32'(wr_data), 32'(dataMem[accIdx - 1]));
        end
        if (!active) begin
            accIdx = 0;
            wrIdx  = 0;
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        pix_valid = 1'b0;
        wr_ready  = 1'b0;
        active    = 1'b0;
        accIdx    = 0;
        wrIdx     = 0;
        wwM       = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Run one transfer to completion or abort. abortAt / errAt are cycle
    // numbers (-1 for never). atDone raises start in the same cycle as the
    // final write handshake.
    task automatic doTransfer(input logic [15:0] b, input logic [15:0] l, input bit w,
                              input logic [15:0] rs, input int pvPct, input int rdyPct,
                              input int abortAt, input int errAt, input bit atDone);
        int cyc;
        bit pv;
        bit rdy;
        bit st;
        applyStimulus(1'b1, b, l, w, rs, 1'b0, 1'b0, 1'b1);
        cyc = 0;
        while (active && cyc < 3000) begin
            pv  = int'($urandom_range(99)) < pvPct;
            rdy = int'($urandom_range(99)) < rdyPct;
            st  = (cyc == errAt) ||
                  (atDone && accIdx == lenM && wrIdx == lenM - 1 && rdy);
            applyStimulus(st, 16'($urandom_range(1, 5)), 16'($urandom_range(1, 5)), 1'b0,
                          16'd0, cyc == abortAt, pv, rdy);
            cyc++;
        end
        if (active) begin
            checkOutput("timeout", 32'd1, 32'd0);
            doReset();
        end
        repeat (2) applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        // Reset values while reset is held.
        rst_n = 1'b0;
        #12;
        checkOutput("rst_wr_valid", 32'(wr_valid), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rst_words", 32'(words_written), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_aborted", 32'(aborted), 32'd0);
        checkOutput("rst_start_err", 32'(start_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_pix_ready", 32'(pix_ready), 32'd0);
        doReset();

        $display("[TB] directed transfers");
        doTransfer(16'h0100, 16'd4, 1'b0, 16'd0, 100, 100, -1, -1, 1'b0);
        doTransfer(16'h0100, 16'd4, 1'b0, 16'd0, 100, 35, -1, -1, 1'b0);
        doTransfer(16'h0010, 16'd7, 1'b1, 16'd3, 100, 100, -1, -1, 1'b0);
        doTransfer(16'h2000, 16'd10, 1'b0, 16'd0, 100, 0, 3, -1, 1'b0);
        doTransfer(16'h3000, 16'd5, 1'b0, 16'd0, 100, 100, -1, -1, 1'b0);
        doTransfer(16'h4000, 16'd0, 1'b0, 16'd0, 100, 100, -1, -1, 1'b0);
        doTransfer(16'h4100, 16'd6, 1'b0, 16'd0, 100, 70, -1, 2, 1'b0);
        doTransfer(16'hFFFE, 16'd4, 1'b0, 16'd0, 100, 100, -1, -1, 1'b0);
        doTransfer(16'h0500, 16'd5, 1'b1, 16'd0, 100, 60, -1, -1, 1'b1);
        checkOutput("words_hold_idle", 32'(words_written), 32'd5);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 40; n++) begin
            doTransfer(16'($urandom),
                       16'($urandom_range(0, 24)),
                       1'($urandom),
                       16'($urandom_range(0, 5)),
                       int'($urandom_range(30, 100)),
                       int'($urandom_range(30, 100)),
                       ($urandom_range(99) < 20) ? int'($urandom_range(0, 20)) : -1,
                       ($urandom_range(99) < 20) ? int'($urandom_range(0, 20)) : -1,
                       1'($urandom_range(99) < 25));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
